// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter and sequencer sharing one external 8-bit ALU between two requesters

module alu_arbiter #(
  parameter int NUM_OPS = 8
) (
  input  logic       clk,
  input  logic       reset_n,

  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [1:0] req0_rot,

  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [1:0] req1_rot,

  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_err,

  output logic [7:0] alu_in0,
  output logic [7:0] alu_in1,
  output logic [3:0] alu_select,
  output logic [1:0] alu_num_rotate,
  input  logic [7:0] alu_out,

  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // One extra bit so an opcode of 15 still compares correctly against a limit of 16.
  localparam logic [4:0] OP_LIMIT = 5'(NUM_OPS);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last;

  logic       grant_valid;
  logic       grant_id;
  logic       accept;

  logic [3:0] op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [1:0] rot_q;
  logic       id_q;

  logic       in_exec;
  logic       op_illegal;

  // Grant selection: on contention the requester that did not win last time goes next.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // Ready is only offered in IDLE and is held low while reset is asserted.
  assign accept     = (state == S_IDLE) && reset_n && grant_valid;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;

  // Next-state logic: one operation in flight, a fixed single EXEC cycle, then wait for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_EXEC;
      S_EXEC:  state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Priority pointer: starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant_id;
    end
  end

  // Operation register: a copy of the granted request, so the requester may move on right after the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q  <= 4'd0;
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      rot_q <= 2'd0;
      id_q  <= 1'b0;
    end else if (accept) begin
      id_q <= grant_id;
      if (grant_id) begin
        op_q  <= req1_op;
        a_q   <= req1_a;
        b_q   <= req1_b;
        rot_q <= req1_rot;
      end else begin
        op_q  <= req0_op;
        a_q   <= req0_a;
        b_q   <= req0_b;
        rot_q <= req0_rot;
      end
    end
  end

  assign in_exec    = (state == S_EXEC);
  assign op_illegal = ({1'b0, op_q} >= OP_LIMIT);

  // ALU drive is gated by state so the ALU sees a quiet pass-of-zero outside EXEC.
  assign alu_in0        = in_exec ? a_q   : 8'd0;
  assign alu_in1        = in_exec ? b_q   : 8'd0;
  assign alu_select     = in_exec ? op_q  : 4'd0;
  assign alu_num_rotate = in_exec ? rot_q : 2'd0;

  // Response register: captured at the end of EXEC and held until the consumer takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_id   <= 1'b0;
      rsp_data <= 8'd0;
      rsp_err  <= 1'b0;
    end else if (in_exec) begin
      rsp_id <= id_q;
      if (op_illegal) begin
        rsp_data <= 8'd0;
        rsp_err  <= 1'b1;
      end else begin
        rsp_data <= alu_out;
        rsp_err  <= 1'b0;
      end
    end else if ((state == S_RESP) && rsp_ready) begin
      rsp_id   <= 1'b0;
      rsp_data <= 8'd0;
      rsp_err  <= 1'b0;
    end
  end

  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU

module tb_alu_arbiter;

  logic       clk;
  logic       reset_n;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic [1:0] req0_rot;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic [1:0] req1_rot;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [7:0] rsp_data;
  logic [7:0] alu_in0, alu_in1, alu_out;
  logic [3:0] alu_select;
  logic [1:0] alu_num_rotate;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int both_ready_seen = 0;

  alu_arbiter #(.NUM_OPS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_rot(req0_rot),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_rot(req1_rot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_select(alu_select),
    .alu_num_rotate(alu_num_rotate), .alu_out(alu_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; unknown selects return 0xAA so an ignored output is visible.
  always_comb begin
    logic [15:0] dbl;
    dbl = {alu_in0, alu_in0};
    alu_out = 8'hAA;
    case (alu_select)
      4'd0: alu_out = alu_in0;
      4'd1: alu_out = alu_in0 & alu_in1;
      4'd2: alu_out = 8'((dbl << alu_num_rotate) >> 8);
      4'd3: alu_out = 8'(dbl >> alu_num_rotate);
      4'd4: alu_out = alu_in0 + alu_in1;
      4'd5: alu_out = alu_in0 - alu_in1;
      4'd6: alu_out = alu_in0 + 8'd1;
      4'd7: alu_out = alu_in0 - 8'd1;
      default: alu_out = 8'hAA;
    endcase
  end

  // Both-ready watchdog across the whole run.
  always @(negedge clk) begin
    if (req0_ready && req1_ready) both_ready_seen = both_ready_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation from a single requester with rsp_ready high: 3 cycles IDLE->EXEC->RESP->IDLE.
  task automatic do_op(input logic id, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [1:0] rot,
                       input logic [7:0] exp_data, input logic exp_err);
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_rot = rot;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_rot = rot;
    end
    #1;
    check("op_ready", {31'd0, id ? req1_ready : req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("op_exec_sel", {28'd0, alu_select}, {28'd0, op});
    tick();
    check("op_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("op_rsp_id",    {31'd0, rsp_id},    {31'd0, id});
    check("op_rsp_data",  {24'd0, rsp_data},  {24'd0, exp_data});
    check("op_rsp_err",   {31'd0, rsp_err},   {31'd0, exp_err});
    tick();
    check("op_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 8'd0; req0_b = 8'd0; req0_rot = 2'd0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 8'd0; req1_b = 8'd0; req1_rot = 2'd0;
    rsp_ready = 1'b0;

    // Reset state, with a request pending that must not be readied.
    tick();
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_alu",        {alu_in0, alu_in1, 4'd0, alu_select, 6'd0, alu_num_rotate}, 32'd0);
    check("rst_rsp",        {22'd0, rsp_id, rsp_err, rsp_data}, 32'd0);
    req0_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Single op: add 2+1 from req0.
    req0_valid = 1'b1; req0_op = 4'd4; req0_a = 8'd2; req0_b = 8'd1; rsp_ready = 1'b1;
    #1;
    check("s_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("s_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    check("s_busy_exec", {31'd0, busy}, 32'd1);
    check("s_alu_sel",   {28'd0, alu_select}, 32'd4);
    check("s_alu_in",    {16'd0, alu_in0, alu_in1}, 32'h0201);
    check("s_no_rsp",    {31'd0, rsp_valid}, 32'd0);
    tick();
    check("s_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("s_rsp",       {22'd0, rsp_id, rsp_err, rsp_data}, 32'h003);
    check("s_alu_quiet", {28'd0, alu_select}, 32'd0);
    tick();
    check("s_retired", {31'd0, rsp_valid}, 32'd0);

    // Reset pulse so the pointer is back at 1 before round robin.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Round robin: req0 sub 2-1=1, req1 and 2&1=0, both continuously valid.
    req0_valid = 1'b1; req0_op = 4'd5; req0_a = 8'd2; req0_b = 8'd1;
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 8'd2; req1_b = 8'd1;
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_ready1", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check("rr_exec_noready", {30'd0, req0_ready, req1_ready}, 32'd0);
      tick();
      check("rr_rsp_id",   {31'd0, rsp_id},   (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_rsp_data", {24'd0, rsp_data}, (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure: req1 rotl 0x81 by 2 = 0x06, consumer stalls 5 cycles.
    req1_valid = 1'b1; req1_op = 4'd2; req1_a = 8'h81; req1_b = 8'd0; req1_rot = 2'd2;
    rsp_ready = 1'b0;
    #1;
    check("bp_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 8'h11;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_rsp",   {22'd0, rsp_id, rsp_err, rsp_data}, 32'h206);
      check("bp_busy",       {31'd0, busy}, 32'd1);
      check("bp_noready",    {30'd0, req0_ready, req1_ready}, 32'd0);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("bp_still_valid", {31'd0, rsp_valid}, 32'd1);
    tick();
    check("bp_retired", {31'd0, rsp_valid}, 32'd0);

    // Rotate right, decrement wrap, illegal op, then a legal op after it.
    do_op(1'b0, 4'd3, 8'h81, 8'h00, 2'd2, 8'h60, 1'b0);
    do_op(1'b0, 4'd7, 8'h00, 8'h00, 2'd0, 8'hFF, 1'b0);
    do_op(1'b1, 4'd9, 8'h05, 8'h03, 2'd0, 8'h00, 1'b1);
    do_op(1'b0, 4'd6, 8'hFF, 8'h00, 2'd0, 8'h00, 1'b0);

    // Reset mid-operation in EXEC, then contention after release.
    req0_valid = 1'b1; req0_op = 4'd4; req0_a = 8'd1; req0_b = 8'd1;
    rsp_ready = 1'b1;
    #1;
    tick();
    check("mr_in_exec", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mr_busy",  {31'd0, busy}, 32'd0);
    check("mr_alu",   {alu_in0, alu_in1, 4'd0, alu_select, 6'd0, alu_num_rotate}, 32'd0);
    check("mr_rsp",   {21'd0, rsp_valid, rsp_id, rsp_err, rsp_data}, 32'd0);
    check("mr_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    tick();
    reset_n = 1'b1;
    req1_valid = 1'b1; req1_op = 4'd0; req1_a = 8'h55;
    #1;
    check("mr_grant0", {30'd0, req0_ready, req1_ready}, 32'd2);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check("mr_rsp_after", {22'd0, rsp_id, rsp_err, rsp_data}, 32'h002);
    tick();

    check("never_both_ready", both_ready_seen, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
